ir_prefetch_queue: RTL and testbench

- Parametrised successor to the single-register instruction latch: a DEPTH-entry prefetch FIFO in front of the instruction register (IR).
- Program-memory fetches can run ahead of execute.
- Sits between the program-memory read port and the decode/execute stage.
- Handles goto (full flush) and skip (annul next instruction into NOP_WORD), with PC tracking per entry.

---
 rtl/ir_prefetch_queue_if.sv | 28 ++
 rtl/ir_prefetch_queue.sv | 83 ++++++++
 tb/tb_ir_prefetch_queue.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/ir_prefetch_queue_if.sv
// ir_prefetch_queue_if: fetch-side, execute-side and IR signals of the prefetch queue
interface ir_prefetch_queue_if #(
    parameter int INST_WIDTH = 12,
    parameter int ADDR_WIDTH = 9,
    parameter int DEPTH = 4
);
    logic                         fetchValid;
    logic [INST_WIDTH-1:0]        programMemIn;
    logic [ADDR_WIDTH-1:0]        fetchPc;
    logic                         fetchReady;
    logic                         advance;
    logic                         goto;
    logic                         skip;
    logic [INST_WIDTH-1:0]        IR;
    logic [ADDR_WIDTH-1:0]        irPc;
    logic                         irValid;
    logic [$clog2(DEPTH+1)-1:0]   count;

    modport master (
        output fetchValid, programMemIn, fetchPc, advance, goto, skip,
        input  fetchReady, IR, irPc, irValid, count
    );

    modport slave (
        input  fetchValid, programMemIn, fetchPc, advance, goto, skip,
        output fetchReady, IR, irPc, irValid, count
    );
endinterface

// File: rtl/ir_prefetch_queue.sv
// ir_prefetch_queue: DEPTH-entry instruction prefetch FIFO feeding the IR,
// with goto flush, skip annulment and a PC carried per entry.
module ir_prefetch_queue #(
    parameter int INST_WIDTH = 12,
    parameter int ADDR_WIDTH = 9,
    parameter int DEPTH = 4,
    parameter logic [INST_WIDTH-1:0] NOP_WORD = 12'h000
) (
    input logic clk,
    input logic rst,
    ir_prefetch_queue_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [INST_WIDTH-1:0] mem_inst [DEPTH];
    logic [ADDR_WIDTH-1:0] mem_pc [DEPTH];
    logic [PW-1:0]         wr_ptr, rd_ptr;
    logic [CW-1:0]         cnt;
    logic [INST_WIDTH-1:0] ir, ld_inst;
    logic [ADDR_WIDTH-1:0] ir_pc, ld_pc;
    logic                  ir_valid, skip_pending;
    logic                  fetch_ready, push, load, pop, bypass, store, annul;

    // fetch_ready comes from registered count only, so a pop never opens a slot the same cycle
    always_comb begin
        fetch_ready = cnt != CW'(DEPTH);
        push = bus.fetchValid && fetch_ready;
        load = bus.advance || !ir_valid;
        pop = load && cnt != '0;
        bypass = load && cnt == '0 && push;
        store = push && !bypass;
        ld_inst = pop ? mem_inst[rd_ptr] : bus.programMemIn;
        ld_pc = pop ? mem_pc[rd_ptr] : bus.fetchPc;
        annul = bus.skip || skip_pending;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt <= '0;
            ir <= NOP_WORD;
            ir_pc <= '0;
            ir_valid <= 1'b0;
            skip_pending <= 1'b0;
        end else if (bus.goto) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt <= '0;
            ir <= NOP_WORD;
            ir_valid <= 1'b0;
            skip_pending <= 1'b0;
        end else begin
            if (store) begin
                mem_inst[wr_ptr] <= bus.programMemIn;
                mem_pc[wr_ptr] <= bus.fetchPc;
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            cnt <= cnt + CW'(store) - CW'(pop);
            if (load && (pop || bypass)) begin
                ir <= annul ? NOP_WORD : ld_inst;
                ir_pc <= ld_pc;
                ir_valid <= 1'b1;
                skip_pending <= 1'b0;
            end else if (load) begin
                ir <= NOP_WORD;
                ir_valid <= 1'b0;
                skip_pending <= annul;
            end else begin
                skip_pending <= annul;
            end
        end
    end

    assign bus.fetchReady = fetch_ready;
    assign bus.IR = ir;
    assign bus.irPc = ir_pc;
    assign bus.irValid = ir_valid;
    assign bus.count = cnt;
endmodule

// File: tb/tb_ir_prefetch_queue.sv
// tb_ir_prefetch_queue: directed and random stimulus against a queue-based reference model
module tb_ir_prefetch_queue;
    localparam int IW = 12;
    localparam int AW = 9;
    localparam int DEPTH = 4;
    localparam logic [IW-1:0] NOP = 12'h000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int vectors = 0;
    int miscompares = 0;

    ir_prefetch_queue_if #(.INST_WIDTH(IW), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) bus ();

    ir_prefetch_queue #(.INST_WIDTH(IW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .NOP_WORD(NOP)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    logic [IW+AW-1:0] m_q[$];
    logic [IW-1:0]    m_ir = NOP;
    logic [AW-1:0]    m_pc = '0;
    logic             m_valid = 1'b0;
    logic             m_sp = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic take(input logic [IW+AW-1:0] w, input logic sk);
        m_ir = (sk || m_sp) ? NOP : w[IW+AW-1:AW];
        m_pc = w[AW-1:0];
        m_valid = 1'b1;
        m_sp = 1'b0;
    endtask

    task automatic model(input logic fv, input logic [IW-1:0] inst, input logic [AW-1:0] pc,
                         input logic adv, input logic gt, input logic sk, input logic rs);
        logic push, ld;
        if (rs) begin
            m_q.delete();
            m_ir = NOP; m_pc = '0; m_valid = 1'b0; m_sp = 1'b0;
        end else if (gt) begin
            m_q.delete();
            m_ir = NOP; m_valid = 1'b0; m_sp = 1'b0;
        end else begin
            push = fv && (m_q.size() < DEPTH);
            ld = adv || !m_valid;
            if (ld && m_q.size() > 0) begin
                take(m_q.pop_front(), sk);
                if (push) m_q.push_back({inst, pc});
            end else if (ld && push) begin
                take({inst, pc}, sk);
            end else begin
                if (push) m_q.push_back({inst, pc});
                if (ld) begin
                    m_ir = NOP; m_valid = 1'b0;
                end
                m_sp = m_sp || sk;
            end
        end
    endtask

    task automatic step(input logic fv, input logic [IW-1:0] inst, input logic [AW-1:0] pc,
                        input logic adv, input logic gt, input logic sk, input logic rs);
        bus.fetchValid = fv; bus.programMemIn = inst; bus.fetchPc = pc;
        bus.advance = adv; bus.goto = gt; bus.skip = sk; rst = rs;
        model(fv, inst, pc, adv, gt, sk, rs);
        @(posedge clk);
        #1;
        chk("ir", 32'(bus.IR), 32'(m_ir));
        chk("ir_pc", 32'(bus.irPc), 32'(m_pc));
        chk("ir_valid", 32'(bus.irValid), 32'(m_valid));
        chk("count", 32'(bus.count), 32'(m_q.size()));
        chk("fetch_ready", 32'(bus.fetchReady), 32'(m_q.size() < DEPTH));
    endtask

    initial begin
        logic [IW-1:0] s_inst;
        logic [AW-1:0] s_pc;
        logic s_fv, adv, gt, sk, rs;
        bus.fetchValid = 0; bus.programMemIn = '0; bus.fetchPc = '0;
        bus.advance = 0; bus.goto = 0; bus.skip = 0;
        @(posedge clk);
        #1;
        // reset held two cycles with a word offered
        step(1, 12'hFFF, 9'h1FF, 0, 0, 0, 1);
        step(1, 12'hFFF, 9'h1FF, 0, 0, 0, 1);
        chk("rst_ir", 32'(bus.IR), 32'h000);
        chk("rst_valid", 32'(bus.irValid), 32'h0);
        chk("rst_count", 32'(bus.count), 32'h0);
        chk("rst_ready", 32'(bus.fetchReady), 32'h1);
        // bypass
        step(1, 12'hA05, 9'h010, 0, 0, 0, 0);
        chk("byp_ir", 32'(bus.IR), 32'hA05);
        chk("byp_pc", 32'(bus.irPc), 32'h010);
        chk("byp_valid", 32'(bus.irValid), 32'h1);
        chk("byp_count", 32'(bus.count), 32'h0);
        // fill to DEPTH, sixth word waits for a freed slot
        for (int i = 1; i <= 4; i++) step(1, 12'hB00 + 12'(i), 9'h010 + 9'(i), 0, 0, 0, 0);
        chk("full_count", 32'(bus.count), 32'h4);
        chk("full_ready", 32'(bus.fetchReady), 32'h0);
        step(1, 12'hB05, 9'h015, 0, 0, 0, 0);
        step(1, 12'hB05, 9'h015, 1, 0, 0, 0);
        chk("pop_ir", 32'(bus.IR), 32'hB01);
        step(1, 12'hB05, 9'h015, 0, 0, 0, 0);
        chk("refill_count", 32'(bus.count), 32'h4);
        for (int i = 0; i < 3 * DEPTH; i++) step(1, 12'hC00 + 12'(i), 9'h040 + 9'(i), 1, 0, 0, 0);
        for (int i = 0; i < DEPTH + 1; i++) step(0, '0, '0, 1, 0, 0, 0);
        // skip with advance
        step(0, '0, '0, 0, 1, 0, 0);
        step(1, 12'h0AA, 9'h020, 0, 0, 0, 0);
        step(1, 12'h111, 9'h021, 0, 0, 0, 0);
        step(1, 12'h222, 9'h022, 0, 0, 0, 0);
        step(0, '0, '0, 1, 0, 1, 0);
        chk("skip_ir", 32'(bus.IR), 32'(NOP));
        chk("skip_valid", 32'(bus.irValid), 32'h1);
        chk("skip_pc", 32'(bus.irPc), 32'h021);
        step(0, '0, '0, 1, 0, 0, 0);
        chk("after_skip_ir", 32'(bus.IR), 32'h222);
        // pending skip
        step(0, '0, '0, 1, 0, 1, 0);
        chk("pend_valid", 32'(bus.irValid), 32'h0);
        step(1, 12'h333, 9'h030, 0, 0, 0, 0);
        chk("pend_ir", 32'(bus.IR), 32'(NOP));
        chk("pend_valid2", 32'(bus.irValid), 32'h1);
        chk("pend_pc", 32'(bus.irPc), 32'h030);
        // goto with skip and push in the same cycle
        step(0, '0, '0, 0, 1, 0, 0);
        for (int i = 0; i < 4; i++) step(1, 12'h500 + 12'(i), 9'h050 + 9'(i), 0, 0, 0, 0);
        chk("pre_goto_count", 32'(bus.count), 32'h3);
        step(1, 12'h777, 9'h077, 1, 1, 1, 0);
        chk("goto_count", 32'(bus.count), 32'h0);
        chk("goto_valid", 32'(bus.irValid), 32'h0);
        chk("goto_ir", 32'(bus.IR), 32'(NOP));
        step(1, 12'h444, 9'h044, 0, 0, 0, 0);
        chk("post_goto_ir", 32'(bus.IR), 32'h444);
        chk("post_goto_count", 32'(bus.count), 32'h0);
        // random traffic; the source holds a word until it is accepted
        s_inst = 12'($urandom); s_pc = 9'($urandom);
        for (int i = 0; i < 600; i++) begin
            s_fv = ($urandom_range(0, 9) < 7);
            adv = $urandom_range(0, 1) == 1;
            gt = $urandom_range(0, 39) == 0;
            sk = $urandom_range(0, 11) == 0;
            rs = $urandom_range(0, 149) == 0;
            if (s_fv && m_q.size() < DEPTH && !gt && !rs) begin
                step(s_fv, s_inst, s_pc, adv, gt, sk, rs);
                s_inst = 12'($urandom); s_pc = 9'($urandom);
            end else begin
                step(s_fv, s_inst, s_pc, adv, gt, sk, rs);
            end
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
